sim_dram_axi_arbiter: RTL

Two-master AXI4 arbiter that shares one SimDRAM AXI slave port between two requesters, e.g. a core memory port and a DMA or loader port in the test harness.
- AR and AW are arbitrated independently, round-robin.
- Master index is appended as the ID MSB on the slave side; R/B responses are routed back by that bit.
- W beats are steered by an in-order FIFO of AW grants.

---
 rtl/sim_dram_axi_arbiter.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sim_dram_axi_arbiter.sv
// Two-master AXI4 arbiter in front of one SimDRAM slave port: round-robin AR/AW, ID-tagged R/B return, W steered by an AW-grant FIFO.
// Optional per-master beat counters and an AW-stall counter are built when ARB_PERF_CNT_EN is defined.
module sim_dram_axi_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 4,
  parameter int WQ_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  // master 0
  input  logic                   m0_ar_valid,
  output logic                   m0_ar_ready,
  input  logic [ADDR_BITS-1:0]   m0_ar_addr,
  input  logic [7:0]             m0_ar_len,
  input  logic [2:0]             m0_ar_size,
  input  logic [ID_BITS-1:0]     m0_ar_id,
  input  logic                   m0_aw_valid,
  output logic                   m0_aw_ready,
  input  logic [ADDR_BITS-1:0]   m0_aw_addr,
  input  logic [7:0]             m0_aw_len,
  input  logic [2:0]             m0_aw_size,
  input  logic [ID_BITS-1:0]     m0_aw_id,
  input  logic                   m0_w_valid,
  output logic                   m0_w_ready,
  input  logic [DATA_BITS-1:0]   m0_w_data,
  input  logic [DATA_BITS/8-1:0] m0_w_strb,
  input  logic                   m0_w_last,
  output logic                   m0_r_valid,
  input  logic                   m0_r_ready,
  output logic [DATA_BITS-1:0]   m0_r_data,
  output logic [1:0]             m0_r_resp,
  output logic                   m0_r_last,
  output logic [ID_BITS-1:0]     m0_r_id,
  output logic                   m0_b_valid,
  input  logic                   m0_b_ready,
  output logic [1:0]             m0_b_resp,
  output logic [ID_BITS-1:0]     m0_b_id,
  // master 1
  input  logic                   m1_ar_valid,
  output logic                   m1_ar_ready,
  input  logic [ADDR_BITS-1:0]   m1_ar_addr,
  input  logic [7:0]             m1_ar_len,
  input  logic [2:0]             m1_ar_size,
  input  logic [ID_BITS-1:0]     m1_ar_id,
  input  logic                   m1_aw_valid,
  output logic                   m1_aw_ready,
  input  logic [ADDR_BITS-1:0]   m1_aw_addr,
  input  logic [7:0]             m1_aw_len,
  input  logic [2:0]             m1_aw_size,
  input  logic [ID_BITS-1:0]     m1_aw_id,
  input  logic                   m1_w_valid,
  output logic                   m1_w_ready,
  input  logic [DATA_BITS-1:0]   m1_w_data,
  input  logic [DATA_BITS/8-1:0] m1_w_strb,
  input  logic                   m1_w_last,
  output logic                   m1_r_valid,
  input  logic                   m1_r_ready,
  output logic [DATA_BITS-1:0]   m1_r_data,
  output logic [1:0]             m1_r_resp,
  output logic                   m1_r_last,
  output logic [ID_BITS-1:0]     m1_r_id,
  output logic                   m1_b_valid,
  input  logic                   m1_b_ready,
  output logic [1:0]             m1_b_resp,
  output logic [ID_BITS-1:0]     m1_b_id,
  // slave port
  output logic                   s_ar_valid,
  input  logic                   s_ar_ready,
  output logic [ADDR_BITS-1:0]   s_ar_addr,
  output logic [7:0]             s_ar_len,
  output logic [2:0]             s_ar_size,
  output logic [ID_BITS:0]       s_ar_id,
  output logic                   s_aw_valid,
  input  logic                   s_aw_ready,
  output logic [ADDR_BITS-1:0]   s_aw_addr,
  output logic [7:0]             s_aw_len,
  output logic [2:0]             s_aw_size,
  output logic [ID_BITS:0]       s_aw_id,
  output logic                   s_w_valid,
  input  logic                   s_w_ready,
  output logic [DATA_BITS-1:0]   s_w_data,
  output logic [DATA_BITS/8-1:0] s_w_strb,
  output logic                   s_w_last,
  input  logic                   s_r_valid,
  output logic                   s_r_ready,
  input  logic [DATA_BITS-1:0]   s_r_data,
  input  logic [1:0]             s_r_resp,
  input  logic                   s_r_last,
  input  logic [ID_BITS:0]       s_r_id,
  input  logic                   s_b_valid,
  output logic                   s_b_ready,
  input  logic [1:0]             s_b_resp,
  input  logic [ID_BITS:0]       s_b_id,
  output logic                   arb_busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [1:0][31:0]       perf_rd_beats,
  output logic [1:0][31:0]       perf_wr_beats,
  output logic [31:0]            perf_aw_stall
`endif
);

  localparam int PTR_BITS = $clog2(WQ_DEPTH);
  localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS + 1)'(WQ_DEPTH);

  // Round-robin pick: the pointer master wins a tie, otherwise whoever is valid.
  function automatic logic rr_pick(input logic ptr, input logic v0, input logic v1);
    return (v0 && v1) ? ptr : v1;
  endfunction

  // Outputs are forced idle while reset is held so nothing handshakes into the cleared state.
  logic run;
  assign run = ~reset;

  // ---------------- AR ----------------
  logic ar_lock_q, ar_lock_d, ar_gnt_q, ar_gnt_d, ar_ptr_q, ar_ptr_d;
  logic ar_gnt, ar_req;

  assign ar_gnt      = ar_lock_q ? ar_gnt_q : rr_pick(ar_ptr_q, m0_ar_valid, m1_ar_valid);
  assign ar_req      = ar_gnt ? m1_ar_valid : m0_ar_valid;
  assign s_ar_valid  = run & ar_req;
  assign s_ar_addr   = ar_gnt ? m1_ar_addr : m0_ar_addr;
  assign s_ar_len    = ar_gnt ? m1_ar_len  : m0_ar_len;
  assign s_ar_size   = ar_gnt ? m1_ar_size : m0_ar_size;
  assign s_ar_id     = {ar_gnt, ar_gnt ? m1_ar_id : m0_ar_id};
  assign m0_ar_ready = run & s_ar_ready & ~ar_gnt;
  assign m1_ar_ready = run & s_ar_ready &  ar_gnt;

  // NOTE: next-state logic gives every _d a default first, so no latch can be inferred.
  always_comb begin
    ar_lock_d = ar_lock_q;
    ar_gnt_d  = ar_gnt_q;
    ar_ptr_d  = ar_ptr_q;
    if (s_ar_valid && s_ar_ready) begin
      ar_lock_d = 1'b0;
      ar_ptr_d  = ~ar_gnt;
    end else if (s_ar_valid) begin
      ar_lock_d = 1'b1;
      ar_gnt_d  = ar_gnt;
    end
  end

  // ---------------- AW + grant FIFO ----------------
  logic aw_lock_q, aw_lock_d, aw_gnt_q, aw_gnt_d, aw_ptr_q, aw_ptr_d;
  logic aw_gnt, aw_req;
  logic                wq_mem_q [WQ_DEPTH];
  logic [PTR_BITS-1:0] wq_wr_q, wq_wr_d, wq_rd_q, wq_rd_d;
  logic [PTR_BITS:0]   wq_cnt_q, wq_cnt_d;
  logic wq_full, wq_empty, wq_push, wq_pop, wq_head;

  assign wq_full  = (wq_cnt_q == FULL_CNT);
  assign wq_empty = (wq_cnt_q == '0);
  assign wq_head  = wq_mem_q[wq_rd_q];

  assign aw_gnt      = aw_lock_q ? aw_gnt_q : rr_pick(aw_ptr_q, m0_aw_valid, m1_aw_valid);
  assign aw_req      = aw_gnt ? m1_aw_valid : m0_aw_valid;
  assign s_aw_valid  = run & ~wq_full & aw_req;
  assign s_aw_addr   = aw_gnt ? m1_aw_addr : m0_aw_addr;
  assign s_aw_len    = aw_gnt ? m1_aw_len  : m0_aw_len;
  assign s_aw_size   = aw_gnt ? m1_aw_size : m0_aw_size;
  assign s_aw_id     = {aw_gnt, aw_gnt ? m1_aw_id : m0_aw_id};
  assign m0_aw_ready = run & ~wq_full & s_aw_ready & ~aw_gnt;
  assign m1_aw_ready = run & ~wq_full & s_aw_ready &  aw_gnt;
  assign wq_push     = s_aw_valid & s_aw_ready;

  always_comb begin
    aw_lock_d = aw_lock_q;
    aw_gnt_d  = aw_gnt_q;
    aw_ptr_d  = aw_ptr_q;
    if (wq_push) begin
      aw_lock_d = 1'b0;
      aw_ptr_d  = ~aw_gnt;
    end else if (s_aw_valid) begin
      aw_lock_d = 1'b1;
      aw_gnt_d  = aw_gnt;
    end
  end

  // ---------------- W ----------------
  logic w_active;
  assign w_active   = run & ~wq_empty;
  assign s_w_valid  = w_active & (wq_head ? m1_w_valid : m0_w_valid);
  assign s_w_data   = wq_head ? m1_w_data : m0_w_data;
  assign s_w_strb   = wq_head ? m1_w_strb : m0_w_strb;
  assign s_w_last   = wq_head ? m1_w_last : m0_w_last;
  assign m0_w_ready = w_active & ~wq_head & s_w_ready;
  assign m1_w_ready = w_active &  wq_head & s_w_ready;
  assign wq_pop     = s_w_valid & s_w_ready & s_w_last;

  always_comb begin
    wq_wr_d  = wq_push ? wq_wr_q + PTR_BITS'(1) : wq_wr_q;
    wq_rd_d  = wq_pop  ? wq_rd_q + PTR_BITS'(1) : wq_rd_q;
    wq_cnt_d = wq_cnt_q;
    if (wq_push && !wq_pop) wq_cnt_d = wq_cnt_q + (PTR_BITS + 1)'(1);
    if (!wq_push && wq_pop) wq_cnt_d = wq_cnt_q - (PTR_BITS + 1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ar_lock_q <= 1'b0;
      ar_gnt_q  <= 1'b0;
      ar_ptr_q  <= 1'b0;
      aw_lock_q <= 1'b0;
      aw_gnt_q  <= 1'b0;
      aw_ptr_q  <= 1'b0;
      wq_wr_q   <= '0;
      wq_rd_q   <= '0;
      wq_cnt_q  <= '0;
    end else begin
      ar_lock_q <= ar_lock_d;
      ar_gnt_q  <= ar_gnt_d;
      ar_ptr_q  <= ar_ptr_d;
      aw_lock_q <= aw_lock_d;
      aw_gnt_q  <= aw_gnt_d;
      aw_ptr_q  <= aw_ptr_d;
      wq_wr_q   <= wq_wr_d;
      wq_rd_q   <= wq_rd_d;
      wq_cnt_q  <= wq_cnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; the count and pointers alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (wq_push) wq_mem_q[wq_wr_q] <= aw_gnt;
  end

  assign arb_busy = run & (~wq_empty | ar_lock_q | aw_lock_q);

  // ---------------- R / B return ----------------
  logic r_sel, b_sel;
  assign r_sel      = s_r_id[ID_BITS];
  assign m0_r_valid = run & s_r_valid & ~r_sel;
  assign m1_r_valid = run & s_r_valid &  r_sel;
  assign s_r_ready  = run & (r_sel ? m1_r_ready : m0_r_ready);
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;
  assign m0_r_id    = s_r_id[ID_BITS-1:0];
  assign m1_r_id    = s_r_id[ID_BITS-1:0];

  assign b_sel      = s_b_id[ID_BITS];
  assign m0_b_valid = run & s_b_valid & ~b_sel;
  assign m1_b_valid = run & s_b_valid &  b_sel;
  assign s_b_ready  = run & (b_sel ? m1_b_ready : m0_b_ready);
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;
  assign m0_b_id    = s_b_id[ID_BITS-1:0];
  assign m1_b_id    = s_b_id[ID_BITS-1:0];

`ifdef ARB_PERF_CNT_EN
  logic [1:0][31:0] perf_rd_q, perf_wr_q;
  logic [31:0]      perf_stall_q;
  logic             w_hs;
  assign w_hs = s_w_valid & s_w_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (m0_r_valid && m0_r_ready) perf_rd_q[0] <= perf_rd_q[0] + 32'd1;
      if (m1_r_valid && m1_r_ready) perf_rd_q[1] <= perf_rd_q[1] + 32'd1;
      if (w_hs && !wq_head)         perf_wr_q[0] <= perf_wr_q[0] + 32'd1;
      if (w_hs &&  wq_head)         perf_wr_q[1] <= perf_wr_q[1] + 32'd1;
      if ((m0_aw_valid || m1_aw_valid) && wq_full) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_rd_beats = perf_rd_q;
  assign perf_wr_beats = perf_wr_q;
  assign perf_aw_stall = perf_stall_q;
`endif

endmodule
